// File: rtl/fusion_uart_tx_if.sv
// Sample-side and serial-side signals of fusion_uart_tx, bundled for port hookup.
interface fusion_uart_tx_if;
  logic [15:0] fusion_in;
  logic        valid_in;
  logic        tx;
  logic        busy;
  logic        overflow;
  logic [7:0]  drop_count;

  modport master (
    output fusion_in, valid_in,
    input  tx, busy, overflow, drop_count
  );

  modport slave (
    input  fusion_in, valid_in,
    output tx, busy, overflow, drop_count
  );
endinterface

// File: rtl/fusion_uart_tx.sv
// Streams fused 16-bit samples over an 8N1 UART as 3-byte frames (sync, msb, lsb),
// buffered by a small drop-on-full FIFO with a saturating drop counter.
module fusion_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic            clk,
  input  logic            rst,
  fusion_uart_tx_if.slave bus
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_DEPTH);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two, 2 or more");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e            state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [15:0]       hold_q, hold_d;
  logic              tx_q, tx_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        drop_q, drop_d;

  logic [15:0]       mem_q [FIFO_DEPTH];
  logic [15:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              fifo_empty, fifo_full;
  logic              pop, push;
  logic              baud_done;
  logic [7:0]        cur_byte;

  // FIFO: pop is decided from pre-edge state, so a full FIFO popping this cycle
  // still has room for a coincident push.
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FIFO_FULL);
    pop        = (state_q == IDLE) && !fifo_empty;
    push       = bus.valid_in && (!fifo_full || pop);

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus.fusion_in;
    end
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    overflow_d = bus.valid_in && fifo_full && !pop;
    drop_d     = drop_q;
    if (overflow_d && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_comb begin
    baud_done = (baud_q == BAUD_LAST);
    case (byte_idx_q)
      2'd0:    cur_byte = SYNC_BYTE;
      2'd1:    cur_byte = hold_q[15:8];
      default: cur_byte = hold_q[7:0];
    endcase

    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    baud_d     = baud_q;
    hold_d     = hold_q;

    case (state_q)
      IDLE: begin
        baud_d    = '0;
        bit_idx_d = '0;
        if (pop) begin
          hold_d     = mem_q[rd_ptr_q];
          byte_idx_d = 2'd0;
          state_d    = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (byte_idx_q < 2'd2) begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the current state through one register, so tx
    // trails the FSM by exactly one cycle throughout the frame.
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte[bit_idx_q];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      baud_q     <= '0;
      hold_q     <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      baud_q     <= baud_d;
      hold_q     <= hold_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = (state_q != IDLE) || (count_q != '0);
  assign bus.overflow   = overflow_q;
  assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_fusion_uart_tx.sv
// Randomized bench for fusion_uart_tx: a cycle-count transaction model predicts
// frames, drops and busy; a UART receiver decodes tx and checks bytes and timing.
module tb_fusion_uart_tx;
  localparam int unsigned CPB          = 4;
  localparam int unsigned DEPTH        = 4;
  localparam logic [7:0]  SYNC         = 8'hA5;
  localparam int unsigned FRAME_CYCLES = 30 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fusion_uart_tx_if bus ();

  fusion_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .SYNC_BYTE   (SYNC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction model: a queue of pending samples and the number of cycles
  // the current frame still occupies the line.
  logic [15:0] m_q[$];
  int unsigned m_rem   = 0;
  int unsigned m_drops = 0;
  logic        m_ovf   = 1'b0;
  int unsigned cyc     = 0;
  logic [7:0]  exp_byte[$];
  int unsigned exp_at[$];

  always @(posedge clk) begin : model
    logic        pop_now;
    logic        full;
    logic [15:0] s;
    cyc++;
    m_ovf = 1'b0;
    if (rst) begin
      m_q.delete();
      m_rem   = 0;
      m_drops = 0;
      exp_byte.delete();
      exp_at.delete();
    end else begin
      pop_now = (m_rem == 0) && (m_q.size() > 0);
      full    = (m_q.size() == DEPTH);
      if (pop_now) begin
        s = m_q.pop_front();
        exp_byte.push_back(SYNC);
        exp_byte.push_back(s[15:8]);
        exp_byte.push_back(s[7:0]);
        for (int k = 0; k < 3; k++) exp_at.push_back(cyc + 1 + k * 10 * CPB);
        m_rem = FRAME_CYCLES;
      end else if (m_rem > 0) begin
        m_rem--;
      end
      if (bus.valid_in) begin
        if (!full || pop_now) m_q.push_back(bus.fusion_in);
        else begin
          m_ovf = 1'b1;
          m_drops++;
        end
      end
    end
  end

  // Per-cycle output checks and a mid-bit-sampling UART receiver.
  int unsigned ovf_seen = 0;
  int unsigned rx_count = 0;
  logic        rx_on    = 1'b0;
  int unsigned rx_cnt   = 0;
  int unsigned rx_t0    = 0;
  logic [7:0]  rx_b     = '0;

  always @(negedge clk) begin
    if (rst) begin
      rx_on = 1'b0;
    end else begin
      chk("busy", bus.busy, (m_rem > 0) || (m_q.size() > 0));
      chk("overflow", bus.overflow, m_ovf);
      chk("drop_count", bus.drop_count, (m_drops > 255) ? 255 : m_drops);
      if (bus.overflow) ovf_seen++;
      if (!rx_on) begin
        if (bus.tx == 1'b0) begin
          rx_on  = 1'b1;
          rx_cnt = 0;
          rx_t0  = cyc;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt == CPB / 2) chk("start_bit", bus.tx, 1'b0);
        for (int b = 0; b < 8; b++)
          if (rx_cnt == CPB * (b + 1) + CPB / 2) rx_b[b] = bus.tx;
        if (rx_cnt == 9 * CPB + CPB / 2) begin
          chk("stop_bit", bus.tx, 1'b1);
          rx_on = 1'b0;
          rx_count++;
          if (exp_byte.size() == 0) begin
            chk("unexpected_byte", rx_b, 32'hFFFF_FFFF);
          end else begin
            chk("rx_byte", rx_b, exp_byte.pop_front());
            chk("rx_start_cycle", rx_t0, exp_at.pop_front());
          end
        end
      end
    end
  end

  task automatic send(input logic [15:0] v);
    bus.valid_in  = 1'b1;
    bus.fusion_in = v;
    @(negedge clk);
    bus.valid_in  = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int unsigned max_cyc);
    int unsigned n = 0;
    while ((bus.busy || rx_on || exp_byte.size() != 0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n < max_cyc, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base, ovf0, drops0, n;
    bus.valid_in  = 1'b0;
    bus.fusion_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", bus.tx, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_overflow", bus.overflow, 1'b0);
    chk("rst_drop_count", bus.drop_count, 8'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single sample
    base = rx_count;
    send(16'h1234);
    chk("single_tx_high_before_start", bus.tx, 1'b1);
    @(negedge clk);
    chk("single_tx_high_pop_cycle", bus.tx, 1'b1);
    @(negedge clk);
    chk("single_tx_start_low", bus.tx, 1'b0);
    wait_idle("single_idle_timeout", 400);
    chk("single_bytes", rx_count - base, 3);
    chk("single_idle_tx", bus.tx, 1'b1);

    // Back-to-back samples
    base = rx_count;
    send(16'h0001);
    send(16'hFFFF);
    send(16'h8000);
    wait_idle("b2b_idle_timeout", 800);
    chk("b2b_bytes", rx_count - base, 9);
    chk("b2b_no_drops", bus.drop_count, 8'd0);

    // Overflow from idle
    ovf0 = ovf_seen;
    for (int i = 0; i < 10; i++) begin
      bus.valid_in  = 1'b1;
      bus.fusion_in = 16'($urandom);
      @(negedge clk);
    end
    bus.valid_in = 1'b0;
    @(negedge clk);
    chk("ovf_pulses", ovf_seen - ovf0, 5);
    chk("ovf_drop_count", bus.drop_count, 8'd5);
    wait_idle("ovf_idle_timeout", 1000);

    // Push coincident with the pop of a full FIFO
    for (int i = 0; i < 5; i++) begin
      bus.valid_in  = 1'b1;
      bus.fusion_in = 16'($urandom);
      @(negedge clk);
    end
    bus.valid_in = 1'b0;
    n = 0;
    while (!(m_rem == 0 && m_q.size() == DEPTH) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("fullpop_wait_timeout", n < 300, 1'b1);
    send(16'hC3E1);
    chk("fullpop_no_overflow", bus.overflow, 1'b0);
    chk("fullpop_drop_count", bus.drop_count, 8'd5);
    chk("fullpop_queued", m_q.size(), DEPTH);
    wait_idle("fullpop_idle_timeout", 1000);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bus.valid_in  = ($urandom_range(0, 5) == 0);
      bus.fusion_in = 16'($urandom);
      @(negedge clk);
    end
    bus.valid_in = 1'b0;
    wait_idle("rand_idle_timeout", 1000);

    // Saturation: continuous valid while frames stall the FIFO
    ovf0   = ovf_seen;
    drops0 = m_drops;
    for (int i = 0; i < 420; i++) begin
      bus.valid_in  = 1'b1;
      bus.fusion_in = 16'($urandom);
      @(negedge clk);
    end
    bus.valid_in = 1'b0;
    @(negedge clk);
    chk("sat_drop_count", bus.drop_count, 8'hFF);
    chk("sat_pulses", ovf_seen - ovf0, m_drops - drops0);
    wait_idle("sat_idle_timeout", 2000);

    // Reset during bit 3 of the MSB byte
    send(16'h5A5A);
    repeat (59) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_tx", bus.tx, 1'b1);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_drop_count", bus.drop_count, 8'd0);
    chk("midrst_overflow", bus.overflow, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_idle_after_release", bus.busy, 1'b0);
    base = rx_count;
    send(16'hABCD);
    wait_idle("midrst_idle_timeout", 400);
    chk("midrst_bytes", rx_count - base, 3);

    chk("all_bytes_received", exp_byte.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
